// File: rtl/mac_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mac_seq_ctrl
//   Initiator-side sequencer for one mac_unit instance. A job (bias + length)
//   is accepted on start, operand pairs are streamed in over valid/ready and
//   forwarded to the MAC, the MAC pipeline is then drained, and the final
//   accumulator value is returned over a valid/ready result port.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   start, len, bias         job request (sampled only in IDLE)
//   busy                     high in every state except IDLE
//   op_valid/op_ready        operand handshake; op_x/op_y operand pair,
//   op_last                  source framing marker (checked only)
//   mac_en, mac_acc_load     MAC en / acc_load
//   mac_x, mac_y, mac_z      MAC X / Y / Z
//   mac_result               MAC Result (fed back)
//   res_valid/res_ready      result handshake; res_data registered result
//   err_last                 sticky op_last framing error for current job
// ---------------------------------------------------------------------------
module mac_seq_ctrl #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32,
    parameter int LEN_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [LEN_W-1:0]         len,
    input  logic signed [ACC_W-1:0]  bias,
    output logic                     busy,
    input  logic                     op_valid,
    output logic                     op_ready,
    input  logic signed [DATA_W-1:0] op_x,
    input  logic signed [DATA_W-1:0] op_y,
    input  logic                     op_last,
    output logic                     mac_en,
    output logic                     mac_acc_load,
    output logic signed [DATA_W-1:0] mac_x,
    output logic signed [DATA_W-1:0] mac_y,
    output logic signed [ACC_W-1:0]  mac_z,
    input  logic signed [ACC_W-1:0]  mac_result,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic signed [ACC_W-1:0]  res_data,
    output logic                     err_last
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_CAPT   = 3'd4;
    localparam logic [2:0] S_RESULT = 3'd5;

    logic [2:0]              state;
    logic [LEN_W-1:0]        rem;        // operand pairs still to accept
    logic signed [ACC_W-1:0] bias_q;
    logic                    drain_cnt;  // 0 = first drain cycle, 1 = second
    logic                    beat;
    logic                    last_beat;

    assign beat      = (state == S_STREAM) && op_valid;
    assign last_beat = (rem == LEN_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            rem       <= '0;
            bias_q    <= '0;
            drain_cnt <= 1'b0;
            res_data  <= '0;
            err_last  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        rem      <= len;
                        bias_q   <= bias;
                        err_last <= 1'b0;
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    drain_cnt <= 1'b0;
                    // Empty job skips streaming; LOAD alone sets acc = bias.
                    state     <= (rem == '0) ? S_DRAIN : S_STREAM;
                end
                S_STREAM: begin
                    if (beat) begin
                        rem <= rem - LEN_W'(1);
                        // Framing is only checked; the count ends the job.
                        if (op_last != last_beat)
                            err_last <= 1'b1;
                        if (last_beat)
                            state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Two zero-operand enables push the last two products
                    // through the MAC's product stages into the accumulator.
                    drain_cnt <= 1'b1;
                    if (drain_cnt)
                        state <= S_CAPT;
                end
                S_CAPT: begin
                    res_data <= mac_result;
                    state    <= S_RESULT;
                end
                S_RESULT: begin
                    if (res_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy         = (state != S_IDLE);
        op_ready     = 1'b0;
        mac_en       = 1'b0;
        mac_acc_load = 1'b0;
        mac_x        = '0;
        mac_y        = '0;
        mac_z        = '0;
        res_valid    = 1'b0;
        case (state)
            S_LOAD: begin
                mac_en       = 1'b1;
                mac_acc_load = 1'b1;
                mac_z        = bias_q;
            end
            S_STREAM: begin
                op_ready = 1'b1;
                // MAC holds on bubbles; operands forced to 0 when invalid.
                mac_en   = op_valid;
                if (op_valid) begin
                    mac_x = op_x;
                    mac_y = op_y;
                end
            end
            S_DRAIN:  mac_en    = 1'b1;
            S_RESULT: res_valid = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
module tb_mac_seq_ctrl;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [7:0]         len;
    logic signed [31:0] bias;
    logic               busy;
    logic               op_valid;
    logic               op_ready;
    logic signed [15:0] op_x, op_y;
    logic               op_last;
    logic               mac_en, mac_acc_load;
    logic signed [15:0] mac_x, mac_y;
    logic signed [31:0] mac_z;
    logic signed [31:0] mac_result;
    logic               res_valid;
    logic               res_ready;
    logic signed [31:0] res_data;
    logic               err_last;

    int total = 0;
    int bad   = 0;

    logic signed [15:0] xs [0:3];
    logic signed [15:0] ys [0:3];
    logic signed [31:0] held;

    always #5 clk = ~clk;

    mac_seq_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .bias(bias),
        .busy(busy), .op_valid(op_valid), .op_ready(op_ready),
        .op_x(op_x), .op_y(op_y), .op_last(op_last),
        .mac_en(mac_en), .mac_acc_load(mac_acc_load),
        .mac_x(mac_x), .mac_y(mac_y), .mac_z(mac_z),
        .mac_result(mac_result), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .err_last(err_last)
    );

    // Behavioural mac_unit: product stage p1, product stage p2, accumulator.
    // Never reset, so stale state is only cleared by the sequencer's LOAD.
    logic signed [31:0] m_p1 = 0, m_p2 = 0, m_acc = 0;
    always @(posedge clk) begin
        if (mac_en) begin
            if (mac_acc_load) begin
                m_p1  <= 0;
                m_p2  <= 0;
                m_acc <= mac_z;
            end else begin
                m_p1  <= 32'($signed(mac_x) * $signed(mac_y));
                m_p2  <= m_p1;
                m_acc <= m_acc + m_p2;
            end
        end
    end
    assign mac_result = m_acc;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Runs a job from start up to the first cycle with res_valid (no handshake).
    task automatic run_job(input string tag, input int n, input logic signed [31:0] b,
                           input int gap, input int lastpos,
                           input logic signed [31:0] exp_res, input logic exp_err);
        int cyc, i, gc, loads, rdy_seen;
        logic gap_ok, acc;
        logic signed [31:0] z_seen;
        cyc = 0; i = 0; gc = 0; loads = 0; rdy_seen = 0; gap_ok = 1'b1; z_seen = 0;
        start = 1'b1; len = 8'(n); bias = b;
        tick();
        start = 1'b0;
        while (!res_valid && cyc < 60) begin
            op_valid = 1'b0; op_x = 0; op_y = 0; op_last = 1'b0;
            if (op_ready && i < n) begin
                if (gc > 0) gc--;
                else begin
                    op_valid = 1'b1; op_x = xs[i]; op_y = ys[i];
                    op_last = (i == lastpos);
                end
            end
            @(negedge clk);
            if (mac_acc_load) begin loads++; z_seen = mac_z; end
            if (op_ready) rdy_seen++;
            if (op_ready && !op_valid && mac_en) gap_ok = 1'b0;
            acc = op_valid && op_ready;
            tick();
            cyc++;
            if (acc) begin i++; gc = gap; end
        end
        op_valid = 1'b0; op_last = 1'b0;
        chk({tag, "_latency"}, cyc, (n == 0) ? 4 : n + 4 + gap * (n - 1));
        chk({tag, "_res_valid"}, res_valid, 1);
        chk({tag, "_res_data"}, res_data, exp_res);
        chk({tag, "_err_last"}, err_last, exp_err);
        chk({tag, "_load_cycles"}, loads, 1);
        chk({tag, "_mac_z"}, z_seen, b);
        if (n == 0) chk({tag, "_op_ready_seen"}, rdy_seen, 0);
        if (gap > 0) chk({tag, "_gap_mac_en_low"}, gap_ok, 1);
    endtask

    task automatic handshake(input string tag);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk({tag, "_idle_busy"}, busy, 0);
        chk({tag, "_idle_res_valid"}, res_valid, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = 0; bias = 0;
        op_valid = 1'b0; op_x = 0; op_y = 0; op_last = 1'b0; res_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_op_ready", op_ready, 0);
        chk("rst_mac_en", mac_en, 0);
        chk("rst_acc_load", mac_acc_load, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_err_last", err_last, 0);
        chk("rst_mac_z", mac_z, 0);
        chk("rst_res_data", res_data, 0);

        // Basic job: 10 + 6 - 20 - 7 = -11
        xs[0] = 2;  ys[0] = 3;
        xs[1] = -4; ys[1] = 5;
        xs[2] = 7;  ys[2] = -1;
        run_job("basic", 3, 10, 0, 2, -11, 1'b0);
        handshake("basic");

        // Same job with 2-cycle bubbles between pairs
        run_job("stall", 3, 10, 2, 2, -11, 1'b0);
        handshake("stall");

        // Empty job returns the bias
        run_job("empty", 0, -5, 0, 0, -5, 1'b0);
        handshake("empty");

        // Backpressure: 7 + 100*(-3) = -293, start pulsed while waiting
        xs[0] = 100; ys[0] = -3;
        run_job("bp", 1, 7, 0, 0, -293, 1'b0);
        held = res_data;
        for (int k = 0; k < 5; k++) begin
            start = (k == 2); len = 0; bias = 123;
            @(negedge clk);
            chk("bp_hold_valid", res_valid, 1);
            chk("bp_hold_data", res_data, held);
            chk("bp_hold_busy", busy, 1);
            tick();
        end
        start = 1'b0;
        handshake("bp");
        tick();
        chk("bp_start_not_queued", busy, 0);

        // Reset after one accepted beat; stale 25 left in the MAC pipeline
        start = 1'b1; len = 3; bias = 1;
        tick();
        start = 1'b0;
        tick();
        op_valid = 1'b1; op_x = 5; op_y = 5; op_last = 1'b0;
        tick();
        op_valid = 1'b0; op_x = 0; op_y = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_op_ready", op_ready, 0);
        chk("midrst_mac_en", mac_en, 0);
        chk("midrst_res_data", res_data, 0);
        chk("midrst_res_valid", res_valid, 0);
        xs[0] = 3; ys[0] = 3;
        xs[1] = 1; ys[1] = 1;
        run_job("after_rst", 2, 0, 0, 1, 10, 1'b0);
        handshake("after_rst");

        // Wrap: 2 * 2^30 = 2^31 -> -2^31; op_last on the wrong beat
        xs[0] = -32768; ys[0] = -32768;
        xs[1] = -32768; ys[1] = -32768;
        run_job("wrap", 2, 0, 0, 0, -32'sd2147483648, 1'b1);
        handshake("wrap");
        chk("wrap_err_held_idle", err_last, 1);

        // Next start clears the sticky error
        run_job("clear_err", 0, 42, 0, 0, 42, 1'b0);
        handshake("clear_err");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mac_seq_ctrl.md
# mac_seq_ctrl

Sequencer that drives the `mac_unit` interface from the initiator side. It accepts a job (bias plus length) and a stream of operand pairs over valid/ready. It then issues the load, accumulate and drain cycles the MAC pipeline needs, and returns the final accumulator value over a valid/ready result port. It sits between an operand source (buffer or DMA) and one `mac_unit` instance, whose result output feeds back into `mac_result`.

## Interface
- `DATA_W`, 16: operand width; signed two's complement.
- `ACC_W`, 32: accumulator/bias/result width; must equal the MAC accumulator width.
- `LEN_W`, 8: width of the job length; jobs cover 0..2^LEN_W-1 pairs.
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: job request; sampled only in IDLE.
- `len` in LEN_W: number of operand pairs; sampled with `start`.
- `bias` in ACC_W signed: initial accumulator value; sampled with `start`.
- `busy` out 1: high from the cycle after `start` is accepted until the result handshake.
- `op_valid` in 1, `op_ready` out 1: operand handshake.
- `op_x`, `op_y` in DATA_W signed: operand pair.
- `op_last` in 1: source marks the final pair; checked only, does not terminate the job.
- `mac_en` out 1, `mac_acc_load` out 1: drive MAC `en` and `acc_load`.
- `mac_x`, `mac_y` out DATA_W; `mac_z` out ACC_W: drive MAC `X`, `Y` and `Z`.
- `mac_result` in ACC_W signed: from MAC `Result`.
- `res_valid` out 1, `res_ready` in 1: result handshake.
- `res_data` out ACC_W signed: registered result.
- `err_last` out 1: sticky `op_last` mismatch flag for the current job.

## Operation
- States: IDLE, LOAD, STREAM, DRAIN, CAPT, RESULT.
- **IDLE**
  - `start`=1 latches `len` and `bias`, clears `err_last`, and goes to LOAD.
  - All MAC drive outputs are 0.
- **LOAD** (1 cycle)
  - Drives `mac_en`=1, `mac_acc_load`=1, `mac_z`=latched bias.
  - This clears both MAC product stages and loads the accumulator.
  - Next state is DRAIN if `len`==0, otherwise STREAM.
- **STREAM**
  - `op_ready`=1.
  - `mac_en`=`op_valid`; `mac_x`/`mac_y` = `op_x`/`op_y` combinationally; both are 0 when `op_valid`=0.
  - Each accepted beat (`op_valid`&&`op_ready`) decrements the remaining count.
  - The beat that takes the count to 0 moves the FSM to DRAIN.
  - While `op_valid`=0, `mac_en`=0 and the MAC pipeline holds.
- **DRAIN** (exactly 2 cycles)
  - Drives `mac_en`=1 with `mac_x`=`mac_y`=0, pushing the last products into the accumulator.
  - Then goes to CAPT.
- **CAPT** (1 cycle): `mac_en`=0; `res_data` <= `mac_result`; then RESULT.
- **RESULT**
  - `res_valid`=1; `res_data` and `err_last` are held stable.
  - On `res_ready`=1, goes to IDLE next cycle.
- `mac_acc_load` is high only in LOAD; `mac_z` is 0 outside LOAD.
- `err_last` is set if `op_last`=1 on any accepted beat other than the final one, or `op_last`=0 on the final beat. It remains valid until the next accepted `start`.
- Arithmetic is done entirely in the MAC.
  - Result = bias + sum of x*y, modulo 2^ACC_W (wraps, no saturation, no overflow flag).
- `busy`=1 in every state except IDLE.

## Timing
- Reset values: state=IDLE; `busy`, `op_ready`, `mac_en`, `mac_acc_load`, `res_valid`, `err_last` = 0; `mac_x`, `mac_y`, `mac_z`, `res_data` = 0.
- `rst` asserted in any state returns the FSM to IDLE on the next edge and discards the job.
  - The MAC is not reset by this block; the next job's LOAD clears the stale MAC pipeline.
- Latency with `start` sampled at edge E0 and `op_valid` held high: `res_valid` rises after edge E0+N+4. Each cycle with `op_valid`=0 in STREAM adds one cycle.
- `len`=0: `res_valid` rises after edge E0+4; `op_ready` never asserts.
- `start` outside IDLE is ignored; no queuing. After the result handshake, the earliest next `start` is accepted in the following (IDLE) cycle.
- `res_valid` stays asserted and `res_data` is stable under backpressure (`res_ready`=0) for any number of cycles.

## Test plan
- **Basic job:** `len`=3, `bias`=10, pairs (2,3), (-4,5), (7,-1) back-to-back.
  - Required: `res_data`=-11 with `res_valid` after E0+7, and `err_last`=0 with `op_last` on the 3rd pair.
- **Stalls:** same job with `op_valid` low for 2 cycles between each pair.
  - Required: `res_data`=-11 at E0+11, and `mac_en`=0 during every gap.
- **Empty job:** `len`=0, `bias`=-5.
  - Required: `res_data`=-5 at E0+4, `op_ready` never high, and `mac_acc_load` high for exactly 1 cycle.
- **Result backpressure:** hold `res_ready`=0 for 5 cycles and pulse `start` during that window.
  - Required: `res_valid`/`res_data` stable, `busy`=1, `start` ignored; after `res_ready`=1, IDLE next cycle.
- **Reset mid-job:** assert `rst` after 1 accepted beat of a `len`=3 job.
  - Required: all outputs 0 next cycle.
  - Then run `len`=2, `bias`=0, pairs (3,3), (1,1): required `res_data`=10, with no stale product.
- **Wrap and framing error:** `len`=2, `bias`=0, pairs (-32768,-32768) twice, `op_last` on the 1st beat only.
  - Required: `res_data`=-2147483648 (wrapped) and `err_last`=1.
